sap_ctrl_seq: RTL

//  Control sequencer for the 5-bit-address SAP datapath. It drives the control lines that the

---
 rtl/sap_ctrl_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sap_ctrl_seq.sv
// Control sequencer for the SAP datapath: one-hot T1..T6 ring with opcode-decoded execute phase.
// Optional variable-length instructions under SAP_CTRL_SKIP_NOP_EN.
module sap_ctrl_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic [3:0] opcode_i,
  output logic [5:0] t_state_o,
  output logic       cp_o,
  output logic       ep_o,
  output logic       lm_n_o,
  output logic       ce_n_o,
  output logic       li_n_o,
  output logic       ei_n_o,
  output logic       la_n_o,
  output logic       ea_o,
  output logic       su_o,
  output logic       eu_o,
  output logic       lb_n_o,
  output logic       lo_n_o,
  output logic       hlt_o
);

  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [1:0] {StIdle, StRing, StHalt} state_e;

  state_e     state_q, state_d;
  logic [5:0] t_q, t_d;
  logic       last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= 6'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

`ifdef SAP_CTRL_SKIP_NOP_EN
  always_comb begin
    last_step = 1'b0;
    unique case (opcode_i)
      OpLda:        last_step = t_q[4];
      OpAdd, OpSub: last_step = t_q[5];
      default:      last_step = t_q[3];
    endcase
  end
`else
  always_comb begin
    last_step = t_q[5];
  end
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      StIdle: begin
        if (run_i) begin
          state_d = StRing;
          t_d     = 6'b000001;
        end
      end
      StRing: begin
        // HLT is checked before the end-of-instruction test so it wins at T4.
        if (t_q[3] && (opcode_i == OpHlt)) begin
          state_d = StHalt;
          t_d     = 6'b0;
        end else if (last_step) begin
          if (run_i) begin
            t_d = 6'b000001;
          end else begin
            state_d = StIdle;
            t_d     = 6'b0;
          end
        end else begin
          t_d = {t_q[4:0], 1'b0};
        end
      end
      StHalt: begin
        t_d = 6'b0;
      end
      default: begin
        state_d = StIdle;
        t_d     = 6'b0;
      end
    endcase
  end

  always_comb begin
    cp_o   = 1'b0;
    ep_o   = 1'b0;
    lm_n_o = 1'b1;
    ce_n_o = 1'b1;
    li_n_o = 1'b1;
    ei_n_o = 1'b1;
    la_n_o = 1'b1;
    ea_o   = 1'b0;
    su_o   = 1'b0;
    eu_o   = 1'b0;
    lb_n_o = 1'b1;
    lo_n_o = 1'b1;
    hlt_o  = (state_q == StHalt);
    if (state_q == StRing) begin
      unique case (1'b1)
        t_q[0]: begin
          ep_o   = 1'b1;
          lm_n_o = 1'b0;
        end
        t_q[1]: cp_o = 1'b1;
        t_q[2]: begin
          ce_n_o = 1'b0;
          li_n_o = 1'b0;
        end
        t_q[3]: begin
          unique case (opcode_i)
            OpLda, OpAdd, OpSub: begin
              ei_n_o = 1'b0;
              lm_n_o = 1'b0;
            end
            OpOut: begin
              ea_o   = 1'b1;
              lo_n_o = 1'b0;
            end
            OpHlt:   hlt_o = 1'b1;
            default: ;
          endcase
        end
        t_q[4]: begin
          unique case (opcode_i)
            OpLda: begin
              ce_n_o = 1'b0;
              la_n_o = 1'b0;
            end
            OpAdd, OpSub: begin
              ce_n_o = 1'b0;
              lb_n_o = 1'b0;
              su_o   = (opcode_i == OpSub);
            end
            default: ;
          endcase
        end
        t_q[5]: begin
          if ((opcode_i == OpAdd) || (opcode_i == OpSub)) begin
            eu_o   = 1'b1;
            la_n_o = 1'b0;
            su_o   = (opcode_i == OpSub);
          end
        end
        default: ;
      endcase
    end
  end

  assign t_state_o = t_q;

endmodule
